// File: rtl/uart_pkg.sv
// uart_pkg: state codes and default bit period shared by the UART transmitter and receiver
// Optional build macro UART_TX_PARITY_EN adds the S_PARITY state code.
package uart_pkg;
    localparam int CLKS_PER_BIT_DEF = 240;
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_SEND_BYTE = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY    = 3'd3,
`endif
        S_STOP      = 3'd4
    } uart_state_t;
endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter, one-cycle tick at count CLKS_PER_BIT-1
// Ports: clk, rst (sync, active-high), clear (hold count at 0), tick (last cycle of a bit period).
module uart_baud_cnt import uart_pkg::*; #(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int W = $clog2(CLKS_PER_BIT);
    logic [W-1:0] cnt;
    assign tick = cnt == W'(CLKS_PER_BIT - 1);
    always_ff @(posedge clk) begin
        if (rst || clear || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: byte-wide valid/ready in, 8N1 serial out (8E1 when UART_TX_PARITY_EN is defined)
// Ports: clk; rst (sync, active-high); tx_data/tx_data_valid byte input;
//        tx_data_ready (registered, byte can be accepted); tx_pin (registered serial line, idles high).
module uart_tx import uart_pkg::*; #(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    output logic       tx_data_ready,
    output logic       tx_pin
);
    uart_state_t state, state_n;
    logic [7:0] data, data_n;
    logic [2:0] idx, idx_n;
    logic       pin_n, ready_n, tick;
    // Counter sits at 0 while idle so the start bit gets a full period from the accept edge.
    uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(state == S_IDLE),
        .tick (tick)
    );
    always_comb begin
        state_n = state;
        data_n  = data;
        idx_n   = idx;
        pin_n   = tx_pin;
        ready_n = tx_data_ready;
        case (state)
            S_IDLE: begin
                pin_n   = 1'b1;
                ready_n = 1'b1;
                if (tx_data_valid && tx_data_ready) begin
                    state_n = S_START;
                    data_n  = tx_data;
                    pin_n   = 1'b0;
                    ready_n = 1'b0;
                end
            end
            S_START: if (tick) begin
                state_n = S_SEND_BYTE;
                pin_n   = data[0];
            end
            S_SEND_BYTE: if (tick) begin
                idx_n = idx + 3'd1;
                if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_n = S_PARITY;
                    pin_n   = ^data;
`else
                    state_n = S_STOP;
                    pin_n   = 1'b1;
`endif
                end else
                    pin_n = data[idx_n];
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: if (tick) begin
                state_n = S_STOP;
                pin_n   = 1'b1;
            end
`endif
            S_STOP: if (tick) begin
                state_n = S_IDLE;
                pin_n   = 1'b1;
                ready_n = 1'b1;
            end
            default: begin
                state_n = S_IDLE;
                pin_n   = 1'b1;
                ready_n = 1'b1;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            data          <= '0;
            idx           <= '0;
            tx_pin        <= 1'b1;
            tx_data_ready <= 1'b0;
        end else begin
            state         <= state_n;
            data          <= data_n;
            idx           <= idx_n;
            tx_pin        <= pin_n;
            tx_data_ready <= ready_n;
        end
    end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 240: clk cycles per serial bit; legal values are 2 or more.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port tx_data, input, 8 bits: byte to transmit.
REQ-005 SHALL have port tx_data_valid, input, 1 bit: tx_data holds a byte to send.
REQ-006 SHALL have port tx_data_ready, output, 1 bit, registered: the block can accept a byte.
REQ-007 SHALL have port tx_pin, output, 1 bit, registered: serial line; idles high.

Function
REQ-008 SHALL implement states S_IDLE, S_START, S_SEND_BYTE, S_PARITY (built only with the macro in REQ-022) and S_STOP.
REQ-009 SHALL accept a byte on a rising edge where tx_data_valid=1 and tx_data_ready=1; tx_data is latched internally on that edge.
- Transitions: S_IDLE -> S_START.
- On that same edge: tx_pin goes to 0 and tx_data_ready goes to 0.
REQ-010 SHALL ignore tx_data_valid while tx_data_ready=0; tx_data changes after acceptance SHALL NOT affect the frame in flight.
REQ-011 SHALL hold each serial bit on tx_pin for exactly CLKS_PER_BIT cycles, counted by a bit-period counter cleared at every bit boundary.
REQ-012 SHALL transmit the frame in this order:
- start bit (0);
- data bits tx_data[0] to tx_data[7], LSB first, selected by a 3-bit index that wraps 7 -> 0;
- optional parity bit;
- one stop bit (1).
REQ-013 SHALL make these transitions at a bit boundary:
- S_START -> S_SEND_BYTE.
- S_SEND_BYTE -> S_PARITY when the macro is defined, otherwise -> S_STOP; taken after bit index 7.
- S_PARITY -> S_STOP.
REQ-014 SHALL, at the end of the stop bit, go S_STOP -> S_IDLE and set tx_data_ready=1 on that edge; tx_pin stays 1.
REQ-015 SHALL support back-to-back frames: with tx_data_valid held high, the next start bit begins exactly one cycle after the previous stop bit ends. The frame period is therefore (10 + P) * CLKS_PER_BIT + 1 cycles, where P=1 with the macro and P=0 without it.
REQ-016 SHALL return to S_IDLE from any undefined state code on the next edge, with tx_pin=1 and tx_data_ready=1.

Reset
REQ-017 SHALL, on any edge with rst=1, set: state S_IDLE, tx_pin=1, tx_data_ready=0, bit-period counter 0, bit index 0.
REQ-018 SHALL drive tx_data_ready=1 on the first edge with rst=0.
REQ-019 SHALL, when reset is asserted mid-frame, abort the frame; tx_pin is 1 on the next edge and no partial frame resumes after reset.
REQ-020 SHALL ignore tx_data_valid while rst=1.

Configuration
REQ-021 SHALL compile without parity when the macro UART_TX_PARITY_EN is undefined: 8N1 frames of 10 bits; S_PARITY is not built.
REQ-022 SHALL, when UART_TX_PARITY_EN is defined, send one even-parity bit (XOR of the 8 data bits) between data bit 7 and the stop bit: 8E1 frames of 11 bits.

Structure
REQ-023 SHALL take its state codes and the default CLKS_PER_BIT constant from shared package uart_pkg, which the receiver also uses.
REQ-024 SHALL place the bit-period counter in sub-module uart_baud_cnt.
- Inputs: clk, rst, clear.
- Output: a one-cycle tick at count CLKS_PER_BIT-1.
- Counter width: ceil(log2(CLKS_PER_BIT)) bits.

Verification
REQ-025 SHALL cover reset release: CLKS_PER_BIT=4, rst high for 3 cycles then low -> tx_pin=1 throughout; tx_data_ready=1 from the first edge with rst=0.
REQ-026 SHALL cover a single byte 0xA5, macro undefined: tx_pin reads 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles wide; tx_data_ready=0 for 40 cycles, then 1.
REQ-027 SHALL cover back-to-back bytes 0x00 then 0xFF, tx_data_valid held high: the second start bit falls exactly 41 cycles after the first; two handshakes occur in total.
REQ-028 SHALL cover valid held while busy: tx_data changed during the frame -> the serial data equals the byte latched at acceptance.
REQ-029 SHALL cover reset mid-frame: rst pulsed at data bit 3 -> tx_pin=1 on the next edge; the next accepted byte 0x3C is transmitted intact.
REQ-030 SHALL cover parity, macro defined: byte 0x07 -> parity bit 1, frame 11 bits (44 cycles); byte 0x03 -> parity bit 0.
